// File: rtl/row_checksum_checker.sv
`default_nettype none
// ============================================================================
// Module   : row_checksum_checker
// Purpose  : Checks one shifted row of N_WORDS words coming out of the
//            circular shifter. It adds the data words mod 2^WORD_W and compares
//            the sum with the checksum word, whose post-shift position is
//            chk_index. The result goes to the fault-correction controller.
//            The check runs one word per cycle. From the capture edge to
//            check_done takes a fixed N_WORDS+1 cycles.
// Ports    : clk            - system clock, all logic on posedge
//            rst            - asynchronous active-high reset
//            row_data_in    - shifted row, word i = bits [WORD_W*i +: WORD_W]
//            row_valid      - shifter ready level, only its rising edge counts
//            chk_index      - checksum word position, sampled with the data
//            busy           - high while a check is in progress
//            check_done     - one-cycle pulse, the result outputs are valid
//            fault_detected - sum mismatch or index error (held)
//            syndrome       - checksum minus data sum, mod 2^WORD_W (held)
//            index_error    - sampled chk_index out of range (held)
//            overrun        - one-cycle pulse, a start was ignored while busy
// Revision : 1.0 - initial release
// ============================================================================
module row_checksum_checker #(
  parameter int WORD_W  = 32,
  parameter int N_WORDS = 33,
  parameter int IDX_W   = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [WORD_W*N_WORDS-1:0] row_data_in,
  input  logic                      row_valid,
  input  logic [IDX_W-1:0]          chk_index,
  output logic                      busy,
  output logic                      check_done,
  output logic                      fault_detected,
  output logic [WORD_W-1:0]         syndrome,
  output logic                      index_error,
  output logic                      overrun
);

  // Highest legal word position. It is also the last value the word counter takes.
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    COMPARE = 2'd2
  } state_t;

  state_t              state;
  logic                row_valid_q;
  logic                armed;
  logic [IDX_W-1:0]    idx_q;
  logic [IDX_W-1:0]    cnt;
  logic [WORD_W-1:0]   acc;
  logic [WORD_W-1:0]   chk_q;
  logic [WORD_W-1:0]   words_q [N_WORDS];

  logic                start;
  logic                capture;
  logic [WORD_W-1:0]   cur_word;
  logic [WORD_W-1:0]   diff;
  logic                idx_bad;

  // armed stays low after reset until row_valid has been seen low. This stops
  // a level that is still high when reset is released from counting as an edge.
  assign start    = row_valid & ~row_valid_q & armed;
  assign capture  = start && (state == IDLE);
  assign cur_word = words_q[cnt];
  assign diff     = chk_q - acc;
  assign idx_bad  = (idx_q > LAST_IDX);

  // The row snapshot is pure data and is qualified by the FSM, so it has no reset.
  always_ff @(posedge clk) begin
    if (capture) begin
      for (int i = 0; i < N_WORDS; i++) begin
        words_q[i] <= row_data_in[i*WORD_W +: WORD_W];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      busy           <= 1'b0;
      check_done     <= 1'b0;
      fault_detected <= 1'b0;
      syndrome       <= '0;
      index_error    <= 1'b0;
      overrun        <= 1'b0;
      row_valid_q    <= 1'b0;
      armed          <= 1'b0;
      idx_q          <= '0;
      cnt            <= '0;
      acc            <= '0;
      chk_q          <= '0;
    end else begin
      row_valid_q <= row_valid;
      if (!row_valid) begin
        armed <= 1'b1;
      end
      check_done <= 1'b0;
      overrun    <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            idx_q <= chk_index;
            acc   <= '0;
            cnt   <= '0;
            // The checksum register is cleared here. An out-of-range index then
            // leaves it at zero, and all words end up in the sum.
            chk_q <= '0;
            busy  <= 1'b1;
            state <= ACCUM;
          end
        end

        ACCUM: begin
          if (cnt == idx_q) begin
            chk_q <= cur_word;
          end else begin
            acc <= acc + cur_word;
          end
          cnt <= cnt + IDX_W'(1);
          if (cnt == LAST_IDX) begin
            state <= COMPARE;
          end
          if (start) begin
            overrun <= 1'b1;
          end
        end

        COMPARE: begin
          syndrome       <= diff;
          index_error    <= idx_bad;
          fault_detected <= (diff != '0) | idx_bad;
          check_done     <= 1'b1;
          busy           <= 1'b0;
          state          <= IDLE;
          if (start) begin
            overrun <= 1'b1;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_row_checksum_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_row_checksum_checker
// Purpose  : Directed, self-checking bench for row_checksum_checker.
//            Each scenario task drives one situation and compares the outputs
//            against hand-computed values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_row_checksum_checker;

  logic          clk;
  logic          rst;
  logic [1055:0] row_data_in;
  logic          row_valid;
  logic [5:0]    chk_index;
  logic          busy;
  logic          check_done;
  logic          fault_detected;
  logic [31:0]   syndrome;
  logic          index_error;
  logic          overrun;

  int checks = 0;
  int errors = 0;

  row_checksum_checker #(
    .WORD_W (32),
    .N_WORDS(33),
    .IDX_W  (6)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .row_data_in   (row_data_in),
    .row_valid     (row_valid),
    .chk_index     (chk_index),
    .busy          (busy),
    .check_done    (check_done),
    .fault_detected(fault_detected),
    .syndrome      (syndrome),
    .index_error   (index_error),
    .overrun       (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Base row: data words 1..32, and the checksum 528 (= 1+2+...+32) in word 32.
  function automatic logic [1055:0] base_row();
    logic [1055:0] r;
    for (int i = 0; i < 32; i++) r[i*32 +: 32] = 32'(i + 1);
    r[32*32 +: 32] = 32'd528;
    return r;
  endfunction

  // Start one check and watch it for 40 edges after the capture edge.
  // The input data is corrupted right after capture, so it must not be used.
  task automatic run_check(input logic [1055:0] row, input logic [5:0] idx,
                           input int hold, output int lat, output int ndone,
                           output logic [31:0] syn, output logic flt,
                           output logic ierr);
    row_data_in = row;
    chk_index   = idx;
    row_valid   = 1'b1;
    @(posedge clk); #1;
    row_data_in = ~row;
    chk_index   = idx ^ 6'h15;
    lat = -1; ndone = 0; syn = 'x; flt = 1'bx; ierr = 1'bx;
    for (int n = 1; n <= 40; n++) begin
      if (n == hold) row_valid = 1'b0;
      @(posedge clk); #1;
      if (check_done === 1'b1) begin
        ndone++;
        if (lat < 0) lat = n;
        syn  = syndrome;
        flt  = fault_detected;
        ierr = index_error;
      end
    end
    row_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; row_valid = 1'b0; chk_index = '0; row_data_in = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if ({busy, check_done, fault_detected, index_error, overrun} !== 5'b0) begin
      errors++; $display("FAIL reset_flags got %b exp 00000", {busy, check_done, fault_detected, index_error, overrun});
    end
    checks++; if (syndrome !== 32'h0) begin
      errors++; $display("FAIL reset_syndrome got %h exp 00000000", syndrome);
    end
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin
      errors++; $display("FAIL reset_idle_busy got %b exp 0", busy);
    end
  endtask

  task automatic test_match();
    int lat, nd; logic [31:0] syn; logic flt, ie;
    run_check(base_row(), 6'd32, 6, lat, nd, syn, flt, ie);
    checks++; if (lat !== 34) begin
      errors++; $display("FAIL match_latency got %0d exp 34", lat);
    end
    checks++; if (nd !== 1) begin
      errors++; $display("FAIL match_done_count got %0d exp 1", nd);
    end
    checks++; if ({flt, ie} !== 2'b00 || syn !== 32'h0) begin
      errors++; $display("FAIL match_result got flt=%b ie=%b syn=%h exp 0 0 00000000", flt, ie, syn);
    end
  endtask

  task automatic test_shifted();
    int lat, nd; logic [31:0] syn; logic flt, ie;
    logic [1055:0] b, r;
    b = base_row();
    for (int j = 0; j < 33; j++) r[j*32 +: 32] = b[((j + 5) % 33)*32 +: 32];
    run_check(r, 6'd27, 1, lat, nd, syn, flt, ie);
    checks++; if (nd !== 1 || flt !== 1'b0 || syn !== 32'h0) begin
      errors++; $display("FAIL shifted got nd=%0d flt=%b syn=%h exp 1 0 00000000", nd, flt, syn);
    end
  endtask

  task automatic test_single_bit_fault();
    int lat, nd; logic [31:0] syn; logic flt, ie;
    logic [1055:0] r;
    r = base_row();
    r[3*32 +: 32] = 32'h0000_0104;
    run_check(r, 6'd32, 1, lat, nd, syn, flt, ie);
    checks++; if (flt !== 1'b1 || ie !== 1'b0) begin
      errors++; $display("FAIL fault_flags got flt=%b ie=%b exp 1 0", flt, ie);
    end
    checks++; if (syn !== 32'hFFFF_FF00) begin
      errors++; $display("FAIL fault_syndrome got %h exp ffffff00", syn);
    end
  endtask

  task automatic test_wrap();
    int lat, nd; logic [31:0] syn; logic flt, ie;
    logic [1055:0] r;
    for (int i = 0; i < 32; i++) r[i*32 +: 32] = 32'hFFFF_FFFF;
    r[32*32 +: 32] = 32'hFFFF_FFE0;
    run_check(r, 6'd32, 1, lat, nd, syn, flt, ie);
    checks++; if (flt !== 1'b0 || syn !== 32'h0) begin
      errors++; $display("FAIL wrap got flt=%b syn=%h exp 0 00000000", flt, syn);
    end
  endtask

  task automatic test_bad_index();
    int lat, nd; logic [31:0] syn; logic flt, ie;
    logic [1055:0] r;
    run_check('0, 6'd40, 1, lat, nd, syn, flt, ie);
    checks++; if ({ie, flt} !== 2'b11 || syn !== 32'h0) begin
      errors++; $display("FAIL bad_index_zero got ie=%b flt=%b syn=%h exp 1 1 00000000", ie, flt, syn);
    end
    // All 33 words of 1 are summed (33), the checksum is 0: syndrome = -33.
    for (int i = 0; i < 33; i++) r[i*32 +: 32] = 32'd1;
    run_check(r, 6'd33, 1, lat, nd, syn, flt, ie);
    checks++; if ({ie, flt} !== 2'b11 || syn !== 32'hFFFF_FFDF) begin
      errors++; $display("FAIL bad_index_ones got ie=%b flt=%b syn=%h exp 1 1 ffffffdf", ie, flt, syn);
    end
  endtask

  task automatic test_overrun();
    int n_ovr, ovr_at, nd; logic [31:0] syn; logic flt;
    n_ovr = 0; ovr_at = -1; nd = 0; syn = 'x; flt = 1'bx;
    row_data_in = base_row(); chk_index = 6'd32; row_valid = 1'b1;
    @(posedge clk); #1;
    for (int n = 1; n <= 40; n++) begin
      if (n == 2)  row_valid = 1'b0;
      if (n == 10) row_valid = 1'b1;
      if (n == 12) row_valid = 1'b0;
      @(posedge clk); #1;
      if (overrun === 1'b1) begin n_ovr++; if (ovr_at < 0) ovr_at = n; end
      if (check_done === 1'b1) begin nd++; syn = syndrome; flt = fault_detected; end
    end
    checks++; if (n_ovr !== 1 || ovr_at !== 10) begin
      errors++; $display("FAIL overrun_pulse got count=%0d at=%0d exp 1 10", n_ovr, ovr_at);
    end
    checks++; if (nd !== 1 || flt !== 1'b0 || syn !== 32'h0) begin
      errors++; $display("FAIL overrun_result got nd=%0d flt=%b syn=%h exp 1 0 00000000", nd, flt, syn);
    end
  endtask

  task automatic test_back_to_back();
    int done_at; logic [1055:0] r;
    r = base_row();
    r[3*32 +: 32] = 32'h0000_0104;
    row_data_in = r; chk_index = 6'd32; row_valid = 1'b1;
    @(posedge clk); #1;
    row_valid = 1'b0;
    done_at = -1;
    for (int n = 1; n <= 40 && done_at < 0; n++) begin
      @(posedge clk); #1;
      if (check_done === 1'b1) done_at = n;
    end
    checks++; if (done_at !== 34) begin
      errors++; $display("FAIL b2b_first_done got %0d exp 34", done_at);
    end
    // Raise the start in the first IDLE cycle after COMPARE.
    row_data_in = base_row(); row_valid = 1'b1;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b1 || overrun !== 1'b0) begin
      errors++; $display("FAIL b2b_accept got busy=%b ovr=%b exp 1 0", busy, overrun);
    end
    row_valid = 1'b0;
    done_at = -1;
    for (int n = 1; n <= 40 && done_at < 0; n++) begin
      @(posedge clk); #1;
      if (n == 20) begin
        checks++; if (syndrome !== 32'hFFFF_FF00 || fault_detected !== 1'b1) begin
          errors++; $display("FAIL b2b_hold got syn=%h flt=%b exp ffffff00 1", syndrome, fault_detected);
        end
      end
      if (check_done === 1'b1) done_at = n;
    end
    checks++; if (done_at !== 34 || syndrome !== 32'h0 || fault_detected !== 1'b0) begin
      errors++; $display("FAIL b2b_second got at=%0d syn=%h flt=%b exp 34 00000000 0", done_at, syndrome, fault_detected);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_check();
    int nd, nb;
    int lat, nd2; logic [31:0] syn; logic flt, ie;
    logic [1055:0] r;
    // Leave a nonzero result held, so the reset clearing it can be seen.
    r = base_row();
    r[3*32 +: 32] = 32'h0000_0104;
    run_check(r, 6'd32, 1, lat, nd2, syn, flt, ie);
    row_data_in = base_row(); chk_index = 6'd32; row_valid = 1'b1;
    @(posedge clk); #1;
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++; if ({busy, check_done, fault_detected, index_error, overrun} !== 5'b0 || syndrome !== 32'h0) begin
      errors++; $display("FAIL midreset_clear got flags=%b syn=%h exp 00000 00000000",
                         {busy, check_done, fault_detected, index_error, overrun}, syndrome);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    // row_valid is still high after reset: it must not start a check.
    nd = 0; nb = 0;
    for (int n = 0; n < 45; n++) begin
      @(posedge clk); #1;
      if (check_done === 1'b1) nd++;
      if (busy === 1'b1) nb++;
    end
    checks++; if (nd !== 0 || nb !== 0) begin
      errors++; $display("FAIL midreset_no_done got done=%0d busy_cycles=%0d exp 0 0", nd, nb);
    end
    row_valid = 1'b0;
    @(posedge clk); #1;
    run_check(base_row(), 6'd32, 1, lat, nd2, syn, flt, ie);
    checks++; if (lat !== 34 || flt !== 1'b0 || syn !== 32'h0) begin
      errors++; $display("FAIL midreset_recover got lat=%0d flt=%b syn=%h exp 34 0 00000000", lat, flt, syn);
    end
  endtask

  initial begin
    test_reset();
    test_match();
    test_shifted();
    test_single_bit_fault();
    test_wrap();
    test_bad_index();
    test_overrun();
    test_back_to_back();
    test_reset_mid_check();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
